// File: rtl/game_pkg.sv
// Shared game-level types and parameter defaults for the score keeper.
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PLAYING   = 2'd1,
      ST_GAME_OVER = 2'd2
   } game_state_e;

   localparam int unsigned DEF_MAX_SCORE      = 99;
   localparam int unsigned DEF_MAX_MISSES     = 3;
   localparam int unsigned DEF_HITS_PER_ROUND = 10;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector: pulse is high in the cycle where d is 1 and was 0
// at the previous clock edge. History resets to 1 so a level already high
// at reset release does not register as an edge.
module rise_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic pulse
);

   logic d_prev_q;
   logic d_prev_d;

   // Next history value is simply the current input level.
   always_comb begin
      d_prev_d = d;
   end

   // History register, preset to 1 during reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) d_prev_q <= 1'b1;
      else      d_prev_q <= d_prev_d;
   end

   // Edge is visible in the same cycle so the consuming update lands on that edge.
   always_comb begin
      pulse = d & ~d_prev_q;
   end

endmodule

// File: rtl/score_keeper.sv
// Score keeper: game FSM (IDLE / PLAYING / GAME_OVER) with saturating score,
// miss counter and round advance, driven by edges of the button/hit/escape levels.
module score_keeper
   import game_pkg::*;
#(
   parameter int unsigned MAX_SCORE      = DEF_MAX_SCORE,
   parameter int unsigned MAX_MISSES     = DEF_MAX_MISSES,
   parameter int unsigned HITS_PER_ROUND = DEF_HITS_PER_ROUND
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       duck_hit,
   input  logic       duck_escaped,
   output logic [6:0] my_score,
   output logic       game_enable,
   output logic       playing,
   output logic       game_over,
   output logic [3:0] misses,
   output logic [3:0] round
);

   localparam logic [6:0] MAX_SCORE_L = 7'(MAX_SCORE);
   localparam logic [3:0] MAX_MISS_L  = 4'(MAX_MISSES);
   localparam logic [7:0] HPR_L       = 8'(HITS_PER_ROUND);
   localparam logic [3:0] ROUND_MAX   = 4'd9;

   logic start_rise, hit_rise, esc_rise;

   game_state_e state_q, state_d;
   logic [6:0]  score_q, score_d;
   logic [3:0]  misses_q, misses_d;
   logic [3:0]  round_q, round_d;
   logic [7:0]  hit_cnt_q, hit_cnt_d;
   logic        game_enable_q, game_enable_d;
   logic        playing_q, playing_d;
   logic        game_over_q, game_over_d;

   rise_edge_det u_start_det (.clk(clk), .rst(rst), .d(start),        .pulse(start_rise));
   rise_edge_det u_hit_det   (.clk(clk), .rst(rst), .d(duck_hit),     .pulse(hit_rise));
   rise_edge_det u_esc_det   (.clk(clk), .rst(rst), .d(duck_escaped), .pulse(esc_rise));

   // Next-state and counter updates; hit has priority over escape, start over both.
   always_comb begin
      state_d   = state_q;
      score_d   = score_q;
      misses_d  = misses_q;
      round_d   = round_q;
      hit_cnt_d = hit_cnt_q;

      unique case (state_q)
         ST_IDLE, ST_GAME_OVER: begin
            if (start_rise) begin
               state_d   = ST_PLAYING;
               score_d   = '0;
               misses_d  = '0;
               round_d   = 4'd1;
               hit_cnt_d = '0;
            end
         end
         ST_PLAYING: begin
            if (hit_rise) begin
               if (score_q < MAX_SCORE_L) score_d = score_q + 7'd1;
               if (hit_cnt_q + 8'd1 >= HPR_L) begin
                  hit_cnt_d = '0;
                  if (round_q < ROUND_MAX) round_d = round_q + 4'd1;
               end else begin
                  hit_cnt_d = hit_cnt_q + 8'd1;
               end
            end else if (esc_rise) begin
               misses_d = misses_q + 4'd1;
               if (misses_d >= MAX_MISS_L) state_d = ST_GAME_OVER;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      game_enable_d = (state_d == ST_PLAYING) || (state_d == ST_GAME_OVER);
      playing_d     = (state_d == ST_PLAYING);
      game_over_d   = (state_d == ST_GAME_OVER);
   end

   // State, counters and decoded status flags, all registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         score_q       <= '0;
         misses_q      <= '0;
         round_q       <= 4'd1;
         hit_cnt_q     <= '0;
         game_enable_q <= 1'b0;
         playing_q     <= 1'b0;
         game_over_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         score_q       <= score_d;
         misses_q      <= misses_d;
         round_q       <= round_d;
         hit_cnt_q     <= hit_cnt_d;
         game_enable_q <= game_enable_d;
         playing_q     <= playing_d;
         game_over_q   <= game_over_d;
      end
   end

   assign my_score    = score_q;
   assign misses      = misses_q;
   assign round       = round_q;
   assign game_enable = game_enable_q;
   assign playing     = playing_q;
   assign game_over   = game_over_q;

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 The block SHALL have parameter MAX_SCORE, default 99, the score saturation value (at most 127).
REQ-002 The block SHALL have parameter MAX_MISSES, default 3, the escaped-duck count that ends the game.
REQ-003 The block SHALL have parameter HITS_PER_ROUND, default 10, the hits needed to advance one round.
REQ-004 clk  input  1  system clock; the block uses one clock.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  level from the start button; only its rising edge is acted on.
REQ-007 duck_hit  input  1  level from hit detection; only its rising edge is acted on.
REQ-008 duck_escaped  input  1  level from the duck controller; only its rising edge is acted on.
REQ-009 my_score  output  7  binary score that feeds the two-digit score display.
REQ-010 game_enable  output  1  score display enable, high in PLAYING and GAME_OVER.
REQ-011 playing  output  1  high only in PLAYING; gates the duck and cursor logic.
REQ-012 game_over  output  1  high only in GAME_OVER.
REQ-013 misses  output  4  escaped-duck count in the current game.
REQ-014 round  output  4  current round, 1..9.

Function
REQ-015 A rising edge SHALL be detected at clock edge N when the input is sampled 1 at N and 0 at N-1; the resulting update is visible from edge N onward.
REQ-016 The FSM SHALL have three states: IDLE, PLAYING and GAME_OVER.
REQ-017 IDLE->PLAYING on a start edge; at the same edge score=0, misses=0, round=1 and the hit-in-round counter=0.
REQ-018 PLAYING->GAME_OVER at the edge where misses reaches MAX_MISSES.
REQ-019 GAME_OVER->PLAYING on a start edge, with the same clearing as REQ-017.
REQ-020 Start edges in PLAYING SHALL be ignored.
REQ-021 Hit and escape edges outside PLAYING SHALL be ignored, and all counters hold.
REQ-022 A hit edge in PLAYING SHALL increment my_score by 1, saturating at MAX_SCORE with no wrap.
REQ-023 A hit edge SHALL increment the hit-in-round counter even when the score is saturated.
REQ-024 When the hit-in-round counter reaches HITS_PER_ROUND it SHALL clear to 0, and round increments, saturating at 9.
REQ-025 An escape edge in PLAYING SHALL increment misses.
REQ-026 Hit and escape edges in the same cycle: the hit is applied and the escape is discarded.
REQ-027 A start edge coincident with a hit or escape edge in IDLE or GAME_OVER: the start is applied, and the hit or escape is discarded.
REQ-028 The score SHALL be held unchanged through GAME_OVER so the display keeps the final value.
REQ-029 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-030 On rst low, asynchronously: state=IDLE, my_score=0, misses=0, round=1, hit counter=0, game_enable=0, playing=0, game_over=0.
REQ-031 On rst low, the edge-detect history registers SHALL be set to 1, so an input already high when reset releases is not seen as an edge.
REQ-032 Reset asserted mid-game SHALL abandon the game with no residual state.

Structure
REQ-033 The state enum typedef and the MAX_SCORE, MAX_MISSES and HITS_PER_ROUND defaults SHALL live in shared package game_pkg.
REQ-034 Rising-edge detection SHALL be a sub-module, rise_edge_det (clk, rst, d, pulse), instantiated three times.

Verification
REQ-035 Scenario 1: reset, then start pulse, then 5 separate hit pulses -> playing=1, game_enable=1, my_score=5, round=1.
REQ-036 Scenario 2: while PLAYING, 120 hit pulses -> my_score stays at 99 after the 99th hit, and round=9.
REQ-037 Scenario 3: while PLAYING, 3 escape pulses -> game_over=1 at the edge of the third escape, playing=0, game_enable=1 and my_score unchanged; a following hit pulse leaves the score unchanged.
REQ-038 Scenario 4: duck_hit and duck_escaped rise in the same cycle with score=4 and misses=1 -> score=5, misses=1.
REQ-039 Scenario 5: from GAME_OVER with score=37, a start pulse -> PLAYING with score=0, misses=0, round=1 on the next cycle.
REQ-040 Scenario 6: duck_hit held high across reset release -> no increment; rst pulsed low mid-game -> all outputs at their REQ-030 values immediately, without waiting for a clock edge.
